// File: rtl/seq_par_arith_top.sv
// -----------------------------------------------------------------------------
// seq_par_arith_top
//
// Two-stage registered arithmetic unit. Stage 1 captures the operands and the
// operation code; stage 2 computes one of four results from those captured
// values and registers it into out. One new operation is accepted every cycle,
// and each result appears exactly two rising edges after its inputs.
//
// Operations (control):
//   00  out = 0
//   01  out = A * B          (6x6 unsigned, 12-bit product)
//   10  out = A * C          (A zero-extended to 12 bits, 24-bit product)
//   11  out = A + B + C      (14-bit unsigned sum, cannot overflow)
//
// Ports:
//   clock      in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   control    in   2   operation select (see table above)
//   A          in   6   unsigned operand
//   B          in   6   unsigned operand
//   C          in  12   unsigned operand
//   out        out 24   registered unsigned result
//   out_valid  out  1   only when SEQ_PAR_VALID_EN is defined: high when out
//                       holds a result of a post-reset capture whose operation
//                       was not 00
//
// Build option: define SEQ_PAR_VALID_EN to add out_valid and its 2-deep valid
// pipeline. Without it the port and logic are absent; the datapath is identical.
// -----------------------------------------------------------------------------
module seq_par_arith_top (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  control,
    input  logic [5:0]  A,
    input  logic [5:0]  B,
    input  logic [11:0] C,
`ifdef SEQ_PAR_VALID_EN
    output logic        out_valid,
`endif
    output logic [23:0] out
);

    typedef enum logic [1:0] {
        OP_ZERO   = 2'b00,
        OP_MUL_AB = 2'b01,
        OP_MUL_AC = 2'b10,
        OP_ADD3   = 2'b11
    } op_e;

    // Stage-1 capture registers
    logic [5:0]  a_q;
    logic [5:0]  b_q;
    logic [11:0] c_q;
    op_e         ctl_q;

    // Stage-2 combinational results, all formed from the same stage-1 sample
    logic [11:0] prod_ab;
    logic [23:0] prod_ac;
    logic [13:0] sum_abc;
    logic [23:0] result;

    // Operands are widened before the operators so every product and sum is
    // evaluated at its full result width rather than truncated to 6 bits.
    assign prod_ab = {6'b0, a_q} * {6'b0, b_q};
    assign prod_ac = {18'b0, a_q} * {12'b0, c_q};
    assign sum_abc = {8'b0, a_q} + {8'b0, b_q} + {2'b0, c_q};

    always_comb begin
        // NOTE: default assignment first so no path leaves result unassigned,
        // which would otherwise infer a latch.
        result = '0;
        case (ctl_q)
            OP_ZERO:   result = '0;
            OP_MUL_AB: result = {12'b0, prod_ab};
            OP_MUL_AC: result = prod_ac;
            OP_ADD3:   result = {10'b0, sum_abc};
            default:   result = '0;
        endcase
    end

    // Both stages live in one clocked process; reset wins over capture and
    // flushes everything in flight.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so stage 2 reads the stage-1 values
        // from before this edge, never the ones being captured now.
        if (reset) begin
            // NOTE: every register is cleared, so nothing in the pipeline is
            // ever undefined after reset.
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            ctl_q <= OP_ZERO;
            out   <= '0;
        end else begin
            a_q   <= A;
            b_q   <= B;
            c_q   <= C;
            ctl_q <= op_e'(control);
            out   <= result;
        end
    end

`ifdef SEQ_PAR_VALID_EN
    // Stage-1 valid marks that the capture registers hold a post-reset sample.
    logic valid_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            valid_q   <= 1'b1;
            out_valid <= valid_q && (ctl_q != OP_ZERO);
        end
    end
`endif

endmodule

// File: tb/tb_seq_par_arith_top.sv
// -----------------------------------------------------------------------------
// tb_seq_par_arith_top
//
// Directed self-checking bench for seq_par_arith_top. Inputs are driven 1 ns
// after a rising edge and outputs are sampled at the same point, so every
// sample sees the register state settled by the most recent edge.
// Define SEQ_PAR_VALID_EN to also connect and check out_valid.
// -----------------------------------------------------------------------------
module tb_seq_par_arith_top;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  control;
    logic [5:0]  A;
    logic [5:0]  B;
    logic [11:0] C;
    logic [23:0] out;
`ifdef SEQ_PAR_VALID_EN
    logic        out_valid;
`endif

    int checks = 0;
    int errors = 0;

    seq_par_arith_top dut (
        .clock     (clock),
        .reset     (reset),
        .control   (control),
        .A         (A),
        .B         (B),
        .C         (C),
`ifdef SEQ_PAR_VALID_EN
        .out_valid (out_valid),
`endif
        .out       (out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [23:0] observed,
                         input logic [23:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_valid(input string tag, input logic expected);
`ifdef SEQ_PAR_VALID_EN
        check(tag, {23'b0, out_valid}, {23'b0, expected});
`endif
    endtask

    task automatic drive(input logic rst, input logic [1:0] ctl,
                         input logic [5:0] a, input logic [5:0] b,
                         input logic [11:0] c);
        reset   = rst;
        control = ctl;
        A       = a;
        B       = b;
        C       = c;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held for two edges with the largest add operands presented.
        drive(1'b1, 2'b11, 6'd63, 6'd63, 12'd4095);
        tick();
        check("reset_edge1", out, 24'd0);
        check_valid("reset_edge1_valid", 1'b0);
        tick();
        check("reset_edge2", out, 24'd0);

        reset = 1'b0;
        tick();
        check("release_edge1", out, 24'd0);
        check_valid("release_edge1_valid", 1'b0);
        tick();
        check("release_edge2_add_max", out, 24'd4221);
        check_valid("release_edge2_valid", 1'b1);

        // Single operations, inputs held for two edges.
        drive(1'b0, 2'b00, 6'd0, 6'd0, 12'd0);
        tick(); tick();
        check("zero_op", out, 24'd0);
        check_valid("zero_op_valid", 1'b0);

        drive(1'b0, 2'b01, 6'd10, 6'd3, 12'd0);
        tick(); tick();
        check("mul_ab_10x3", out, 24'd30);
        check_valid("mul_ab_valid", 1'b1);

        drive(1'b0, 2'b01, 6'd63, 6'd63, 12'd0);
        tick(); tick();
        check("mul_ab_max", out, 24'd3969);

        drive(1'b0, 2'b10, 6'd5, 6'd0, 12'd7);
        tick(); tick();
        check("mul_ac_5x7", out, 24'd35);

        drive(1'b0, 2'b10, 6'd63, 6'd0, 12'd4095);
        tick(); tick();
        check("mul_ac_max", out, 24'd257985);

        drive(1'b0, 2'b11, 6'd1, 6'd2, 12'd3);
        tick(); tick();
        check("add_1_2_3", out, 24'd6);

        // Flush with a zero op so the back-to-back results are distinct.
        drive(1'b0, 2'b00, 6'd0, 6'd0, 12'd0);
        tick(); tick();
        check("flush", out, 24'd0);

        // Back-to-back, new operation every cycle.
        drive(1'b0, 2'b01, 6'd2, 6'd3, 12'd0);
        tick();
        check("b2b_edge1", out, 24'd0);
        check_valid("b2b_edge1_valid", 1'b0);
        drive(1'b0, 2'b10, 6'd4, 6'd0, 12'd100);
        tick();
        check("b2b_op1_mul_ab", out, 24'd6);
        check_valid("b2b_op1_valid", 1'b1);
        drive(1'b0, 2'b11, 6'd1, 6'd1, 12'd1);
        tick();
        check("b2b_op2_mul_ac", out, 24'd400);
        check_valid("b2b_op2_valid", 1'b1);
        drive(1'b0, 2'b00, 6'd0, 6'd0, 12'd0);
        tick();
        check("b2b_op3_add", out, 24'd3);
        check_valid("b2b_op3_valid", 1'b1);
        tick();
        check("b2b_op4_zero", out, 24'd0);
        check_valid("b2b_op4_valid", 1'b0);

        // Reset between op 2 and op 3 drops the in-flight results.
        drive(1'b0, 2'b01, 6'd2, 6'd3, 12'd0);
        tick();
        drive(1'b0, 2'b10, 6'd4, 6'd0, 12'd100);
        tick();
        check("mid_op1", out, 24'd6);
        drive(1'b1, 2'b11, 6'd1, 6'd1, 12'd1);
        tick();
        check("mid_reset_drops_op2", out, 24'd0);
        check_valid("mid_reset_valid", 1'b0);
        reset = 1'b0;
        tick();
        check("mid_release_edge1", out, 24'd0);
        check_valid("mid_release_edge1_valid", 1'b0);
        tick();
        check("mid_release_edge2_op3", out, 24'd3);
        check_valid("mid_release_edge2_valid", 1'b1);

        // out must hold between edges.
        #4;
        check("hold_between_edges", out, 24'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
